// File: rtl/clk_meas_pkg.sv
// Shared types and default constants for the divided-clock edge meter.
package clk_meas_pkg;

    // Tracking state of the edge meter.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        LOCKED = 2'd2,
        LOST   = 2'd3
    } meas_state_t;

    localparam int DEF_CNT_W       = 16;
    localparam int DEF_TIMEOUT     = 50000;
    localparam int DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/sync_edge.sv
// Level synchronizer with edge detection for an asynchronous input.
// The chain depth must be at least 2. The *_now outputs are the
// combinational edge terms; the *_pulse outputs are the same terms one
// register later, so a consumer can register its own reaction to *_now
// and have it line up with *_pulse.
module sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise_now,
    output logic fall_now,
    output logic rise_pulse,
    output logic fall_pulse
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   level;

    assign level    = sync_q[SYNC_STAGES-1];
    assign rise_now = level & ~prev_q;
    assign fall_now = ~level & prev_q;

    // Synchronizer chain, previous-sample flop and registered edge strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q     <= '0;
            prev_q     <= 1'b0;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], din};
            prev_q     <= level;
            rise_pulse <= rise_now;
            fall_pulse <= fall_now;
        end
    end

endmodule

// File: rtl/clk_edge_meter.sv
// Divided-clock consumer: synchronizes a slow toggling input, emits
// rise/fall strobes for use as clock enables, measures the rise-to-rise
// period and reports lock/loss.
// Optional: define CLK_EDGE_METER_DUTY_EN to add the high_time output
// (cycles the input was high during the last complete period).
//
// state  | meaning
// IDLE   | after reset, waiting for the first rising edge
// ARMED  | one edge seen, counting toward the first period
// LOCKED | period measured, tracking every rise
// LOST   | no rise within TIMEOUT cycles, waiting for a rise to re-arm
module clk_edge_meter
    import clk_meas_pkg::*;
#(
    parameter int CNT_W       = DEF_CNT_W,
    parameter int TIMEOUT     = DEF_TIMEOUT,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_d_in,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             locked,
    output logic             lost
`ifdef CLK_EDGE_METER_DUTY_EN
    ,
    output logic [CNT_W-1:0] high_time
`endif
);

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(TIMEOUT);

    meas_state_t      state;
    meas_state_t      state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] period_nxt;
    logic             pv_nxt;
    logic             rise_now;
    logic             fall_now;
    logic             timeout_hit;

    sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_edge (
        .clk       (clk),
        .rst       (rst),
        .din       (clk_d_in),
        .rise_now  (rise_now),
        .fall_now  (fall_now),
        .rise_pulse(rise_pulse),
        .fall_pulse(fall_pulse)
    );

    assign timeout_hit = (cnt == TIMEOUT_V);

    // Next-state, period capture and counter update; a rise beats a timeout.
    always_comb begin
        state_nxt  = state;
        period_nxt = period;
        pv_nxt     = 1'b0;
        cnt_nxt    = cnt;

        case (state)
            IDLE: begin
                if (rise_now) state_nxt = ARMED;
            end
            ARMED: begin
                if (rise_now) begin
                    state_nxt  = LOCKED;
                    period_nxt = cnt;
                    pv_nxt     = 1'b1;
                end else if (timeout_hit) begin
                    state_nxt = LOST;
                end
            end
            LOCKED: begin
                if (rise_now) begin
                    period_nxt = cnt;
                    pv_nxt     = 1'b1;
                end else if (timeout_hit) begin
                    state_nxt = LOST;
                end
            end
            LOST: begin
                if (rise_now) state_nxt = ARMED;
            end
            default: state_nxt = IDLE;
        endcase

        if (rise_now) begin
            cnt_nxt = CNT_ONE;
        end else if (state == IDLE || state == LOST) begin
            cnt_nxt = '0;
        end else if (cnt != CNT_MAX) begin
            cnt_nxt = cnt + CNT_ONE;
        end
    end

    // State, counter and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            period       <= '0;
            period_valid <= 1'b0;
            locked       <= 1'b0;
            lost         <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            period       <= period_nxt;
            period_valid <= pv_nxt;
            locked       <= (state_nxt == LOCKED);
            lost         <= (state_nxt == LOST);
        end
    end

`ifdef CLK_EDGE_METER_DUTY_EN
    logic [CNT_W-1:0] high_cap;

    // The count at a fall is the number of high cycles since the last rise;
    // it is held until the next rise publishes it alongside the period.
    always_ff @(posedge clk) begin
        if (rst) begin
            high_cap  <= '0;
            high_time <= '0;
        end else begin
            if (fall_now) high_cap <= cnt;
            if (pv_nxt)   high_time <= high_cap;
        end
    end
`endif

endmodule

// File: tb/tb_clk_edge_meter.sv
// Self-checking bench for clk_edge_meter: directed scenarios followed by
// random half-period segments, checked cycle by cycle against an
// event-level reference model (rise times, elapsed cycles, tracking phase).
module tb_clk_edge_meter;

    localparam int CNT_W   = 16;
    localparam int TMO     = 100;
    localparam int SYNC    = 2;

    localparam int PH_IDLE   = 0;
    localparam int PH_ARMED  = 1;
    localparam int PH_LOCKED = 2;
    localparam int PH_LOST   = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             clk_d_in = 1'b0;
    logic             rise_pulse;
    logic             fall_pulse;
    logic [CNT_W-1:0] period;
    logic             period_valid;
    logic             locked;
    logic             lost;
`ifdef CLK_EDGE_METER_DUTY_EN
    logic [CNT_W-1:0] high_time;
`endif

    clk_edge_meter #(
        .CNT_W      (CNT_W),
        .TIMEOUT    (TMO),
        .SYNC_STAGES(SYNC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .clk_d_in    (clk_d_in),
        .rise_pulse  (rise_pulse),
        .fall_pulse  (fall_pulse),
        .period      (period),
        .period_valid(period_valid),
        .locked      (locked),
        .lost        (lost)
`ifdef CLK_EDGE_METER_DUTY_EN
        ,
        .high_time   (high_time)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state.
    logic [SYNC+1:0] hist = '0;
    int cyc       = 0;
    int last_rise = 0;
    int phase     = PH_IDLE;
    int e_rise    = 0;
    int e_fall    = 0;
    int e_pv      = 0;
    int e_period  = 0;
    int e_high    = 0;
    int hcap      = 0;
    logic lvl     = 1'b0;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock: drive inputs, advance the model, compare every output.
    task automatic step(input logic din, input logic r);
        clk_d_in = din;
        rst      = r;
        @(posedge clk);
        #1;
        cyc++;
        if (r) begin
            hist     = '0;
            phase    = PH_IDLE;
            e_rise   = 0;
            e_fall   = 0;
            e_pv     = 0;
            e_period = 0;
            e_high   = 0;
            hcap     = 0;
        end else begin
            hist   = {hist[SYNC:0], din};
            e_rise = int'(hist[SYNC] & ~hist[SYNC+1]);
            e_fall = int'(~hist[SYNC] & hist[SYNC+1]);
            e_pv   = 0;
            if (e_fall != 0)
                hcap = (phase == PH_ARMED || phase == PH_LOCKED) ? cyc - last_rise : 0;
            if (e_rise != 0) begin
                if (phase == PH_ARMED || phase == PH_LOCKED) begin
                    e_pv     = 1;
                    e_period = cyc - last_rise;
                    e_high   = hcap;
                    phase    = PH_LOCKED;
                end else begin
                    phase = PH_ARMED;
                end
                last_rise = cyc;
            end else if ((phase == PH_ARMED || phase == PH_LOCKED) &&
                         (cyc - last_rise == TMO)) begin
                phase = PH_LOST;
            end
        end
        chk("rise_pulse",   int'(rise_pulse),   e_rise);
        chk("fall_pulse",   int'(fall_pulse),   e_fall);
        chk("period_valid", int'(period_valid), e_pv);
        chk("period",       int'(period),       e_period);
        chk("locked",       int'(locked),       int'(phase == PH_LOCKED));
        chk("lost",         int'(lost),         int'(phase == PH_LOST));
`ifdef CLK_EDGE_METER_DUTY_EN
        chk("high_time",    int'(high_time),    e_high);
`endif
    endtask

    task automatic seg(input logic level, input int n);
        lvl = level;
        for (int i = 0; i < n; i++) step(level, 1'b0);
    endtask

    task automatic toggle(input int hi, input int lo, input int periods);
        for (int i = 0; i < periods; i++) begin
            seg(1'b1, hi);
            seg(1'b0, lo);
        end
    endtask

    initial begin
        // Reset held three cycles, then a quiet low input.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
        chk("reset_period", int'(period), 0);
        chk("reset_locked", int'(locked), 0);
        seg(1'b0, 20);
        chk("idle_locked", int'(locked), 0);
        chk("idle_lost", int'(lost), 0);

        // Fast source: 2 high / 2 low.
        toggle(2, 2, 10);
        chk("fast_locked", int'(locked), 1);
        chk("fast_period", int'(period), 4);

        // Source slows to 5 / 5 while locked.
        toggle(5, 5, 6);
        chk("slow_locked", int'(locked), 1);
        chk("slow_period", int'(period), 10);

        // Period exactly TIMEOUT: rise and timeout coincide, rise wins.
        toggle(50, 50, 3);
        seg(1'b1, 120);
        chk("tie_period", int'(period), 100);
        chk("frozen_lost", int'(lost), 1);
        chk("frozen_locked", int'(locked), 0);

        // Recover: one rise re-arms, the next relocks.
        seg(1'b0, 5);
        seg(1'b1, 5);
        chk("rearm_lost", int'(lost), 0);
        chk("rearm_locked", int'(locked), 0);
        seg(1'b0, 5);
        seg(1'b1, 5);
        seg(1'b0, 5);
        chk("relock_locked", int'(locked), 1);
        chk("relock_period", int'(period), 10);

        // Period one past TIMEOUT drops lock before the late rise.
        seg(1'b1, 51);
        seg(1'b0, 50);
        seg(1'b1, 5);
        chk("late_locked", int'(locked), 0);
        chk("late_lost", int'(lost), 0);
        seg(1'b0, 5);

        // Reset mid-period while locked.
        toggle(5, 5, 3);
        seg(1'b1, 2);
        step(1'b1, 1'b1);
        chk("midrst_period", int'(period), 0);
        chk("midrst_locked", int'(locked), 0);
        seg(1'b1, 3);
        toggle(5, 5, 1);
        chk("midrst_one_rise", int'(locked), 0);
        toggle(5, 5, 2);
        chk("midrst_relock", int'(locked), 1);

        // Random segments, including long freezes around TIMEOUT and resets.
        for (int i = 0; i < 200; i++) begin
            int sel;
            sel = int'($urandom_range(0, 19));
            if (sel == 0) begin
                seg(~lvl, int'($urandom_range(90, 130)));
            end else if (sel == 1) begin
                step(lvl, 1'b1);
            end else begin
                seg(~lvl, int'($urandom_range(1, 30)));
            end
        end

        // Asymmetric duty: 3 high / 5 low.
        seg(1'b0, 8);
        toggle(3, 5, 6);
        chk("duty_period", int'(period), 8);
        chk("duty_locked", int'(locked), 1);
`ifdef CLK_EDGE_METER_DUTY_EN
        chk("duty_high", int'(high_time), 3);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
